debug_uart_tx_arbiter: RTL and testbench

//   Shares the single OCD UART transmitter between two requesters:
//   - the debug reply engine, whose reply frames are atomic;
//   - a CPU console byte stream, buffered in a small FIFO.
//   A debug frame owns the UART from frame request to frame done, and no console byte is interleaved.

---
 rtl/debug_coprocessor_pkg.sv | 14 +
 rtl/debug_uart_tx_arbiter_fifo.sv | 49 ++++
 rtl/debug_uart_tx_arbiter.sv | 141 ++++++++++++++
 tb/tb_debug_uart_tx_arbiter.sv | 351 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/debug_coprocessor_pkg.sv
// Shared constants and types for the debug coprocessor blocks.
package debug_coprocessor;

    localparam int unsigned DEBUG_DATA_WIDTH   = 8;
    localparam int unsigned DBG_ARB_FIFO_DEPTH = 4;

    typedef enum logic [3:0] {
        IDLE    = 4'b0001,
        CON_TX  = 4'b0010,
        DBG_OWN = 4'b0100,
        DBG_TX  = 4'b1000
    } arb_state_t;

endpackage

// File: rtl/debug_uart_tx_arbiter_fifo.sv
// Synchronous byte FIFO for the console stream; one extra pointer bit separates full from empty.
module debug_byte_fifo #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned DEPTH      = 4
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] push_data,
    input  logic                  pop,
    output logic [DATA_WIDTH-1:0] head,
    output logic                  full,
    output logic                  empty
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [AW:0]           wr_ptr_q;
    logic [AW:0]           rd_ptr_q;
    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic                  do_push;
    logic                  do_pop;

    assign empty   = (wr_ptr_q == rd_ptr_q);
    assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign head    = mem_q[rd_ptr_q[AW-1:0]];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q[AW-1:0]] <= push_data;
                wr_ptr_q                <= wr_ptr_q + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
        end
    end

endmodule

// File: rtl/debug_uart_tx_arbiter.sv
// Shares the OCD UART transmitter between atomic debug reply frames and a buffered console stream.
module debug_uart_tx_arbiter
    import debug_coprocessor::*;
#(
    parameter int unsigned DATA_WIDTH         = DEBUG_DATA_WIDTH,
    parameter int unsigned CON_FIFO_DEPTH     = DBG_ARB_FIFO_DEPTH,
    parameter int unsigned DBG_TIMEOUT_CYCLES = 65535
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  dbg_frame_req,
    input  logic                  dbg_frame_done,
    input  logic                  dbg_start_tx,
    input  logic [DATA_WIDTH-1:0] dbg_data,
    output logic                  dbg_tx_done,
    input  logic                  con_valid,
    input  logic [DATA_WIDTH-1:0] con_data,
    output logic                  con_ready,
    output logic                  uart_start_tx,
    output logic [DATA_WIDTH-1:0] uart_data,
    input  logic                  uart_tx_done,
    output logic                  dbg_timeout_err
);

    localparam int unsigned WD_W = $clog2(DBG_TIMEOUT_CYCLES + 1);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(DBG_TIMEOUT_CYCLES - 1);

    arb_state_t            state_q, state_d;
    logic                  dbg_pend_q, dbg_pend_d;
    logic                  start_pend_q, start_pend_d;
    logic [WD_W-1:0]       wd_q, wd_d;
    logic                  uart_start_q, uart_start_d;
    logic [DATA_WIDTH-1:0] uart_data_q, uart_data_d;
    logic                  timeout_q, timeout_d;

    logic                  fifo_pop;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic [DATA_WIDTH-1:0] fifo_head;

    debug_byte_fifo #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (CON_FIFO_DEPTH)
    ) u_con_fifo (
        .clk       (clk),
        .reset_n   (reset_n),
        .push      (con_valid),
        .push_data (con_data),
        .pop       (fifo_pop),
        .head      (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    always_comb begin
        state_d      = state_q;
        dbg_pend_d   = dbg_pend_q;
        start_pend_d = start_pend_q;
        wd_d         = '0;
        uart_start_d = 1'b0;
        uart_data_d  = uart_data_q;
        timeout_d    = 1'b0;
        fifo_pop     = 1'b0;

        // Requests arriving before ownership are remembered so nothing is lost during CON_TX.
        if (dbg_frame_req && (state_q == IDLE || state_q == CON_TX)) begin
            dbg_pend_d = 1'b1;
        end
        if (dbg_start_tx && state_q != DBG_OWN) begin
            start_pend_d = 1'b1;
        end

        unique case (state_q)
            IDLE: begin
                if (dbg_pend_q || dbg_frame_req) begin
                    state_d    = DBG_OWN;
                    dbg_pend_d = 1'b0;
                end else if (!fifo_empty) begin
                    fifo_pop     = 1'b1;
                    uart_data_d  = fifo_head;
                    uart_start_d = 1'b1;
                    state_d      = CON_TX;
                end
            end
            CON_TX: begin
                if (uart_tx_done) begin
                    state_d = IDLE;
                end
            end
            DBG_OWN: begin
                // A start coincident with frame done is dropped along with any latched one.
                start_pend_d = 1'b0;
                if (dbg_frame_done) begin
                    state_d = IDLE;
                end else if (dbg_start_tx || start_pend_q) begin
                    uart_data_d  = dbg_data;
                    uart_start_d = 1'b1;
                    state_d      = DBG_TX;
                end else if (wd_q == WD_LAST) begin
                    timeout_d = 1'b1;
                    state_d   = IDLE;
                end else begin
                    wd_d = wd_q + 1'b1;
                end
            end
            DBG_TX: begin
                if (uart_tx_done) begin
                    state_d = DBG_OWN;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            dbg_pend_q   <= 1'b0;
            start_pend_q <= 1'b0;
            wd_q         <= '0;
            uart_start_q <= 1'b0;
            uart_data_q  <= '0;
            timeout_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            dbg_pend_q   <= dbg_pend_d;
            start_pend_q <= start_pend_d;
            wd_q         <= wd_d;
            uart_start_q <= uart_start_d;
            uart_data_q  <= uart_data_d;
            timeout_q    <= timeout_d;
        end
    end

    assign uart_start_tx   = uart_start_q;
    assign uart_data       = uart_data_q;
    assign dbg_timeout_err = timeout_q;
    assign con_ready       = ~fifo_full;
    assign dbg_tx_done     = uart_tx_done & (state_q == DBG_TX);

endmodule

// File: tb/tb_debug_uart_tx_arbiter.sv
// Scoreboard bench: console bytes keep FIFO order, bytes started inside a debug frame are debug bytes.
module tb_debug_uart_tx_arbiter;

    localparam int unsigned DW    = 8;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned TMO   = 16;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          dbg_frame_req = 1'b0;
    logic          dbg_frame_done = 1'b0;
    logic          dbg_start_tx = 1'b0;
    logic [DW-1:0] dbg_data = '0;
    logic          dbg_tx_done;
    logic          con_valid = 1'b0;
    logic [DW-1:0] con_data = '0;
    logic          con_ready;
    logic          uart_start_tx;
    logic [DW-1:0] uart_data;
    logic          uart_tx_done = 1'b0;
    logic          dbg_timeout_err;

    int checks = 0;
    int passes = 0;

    // Reference model: expected byte streams, FIFO occupancy, frame window.
    logic [DW-1:0] con_exp[$];
    logic [DW-1:0] dbg_exp[$];
    int pushed = 0;
    int con_sent = 0;
    int err_due = -1;
    int lat_cyc = -1;
    int cyc = 0;
    bit win = 1'b0;
    bit win_prev = 1'b0;
    bit inflight_dbg = 1'b0;
    bit uart_stall = 1'b0;
    bit u_busy = 1'b0;
    int u_wait = 0;

    debug_uart_tx_arbiter #(
        .DATA_WIDTH         (DW),
        .CON_FIFO_DEPTH     (DEPTH),
        .DBG_TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .dbg_frame_req   (dbg_frame_req),
        .dbg_frame_done  (dbg_frame_done),
        .dbg_start_tx    (dbg_start_tx),
        .dbg_data        (dbg_data),
        .dbg_tx_done     (dbg_tx_done),
        .con_valid       (con_valid),
        .con_data        (con_data),
        .con_ready       (con_ready),
        .uart_start_tx   (uart_start_tx),
        .uart_data       (uart_data),
        .uart_tx_done    (uart_tx_done),
        .dbg_timeout_err (dbg_timeout_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: actual %0h required %0h (t=%0t)", name, act, exp, $time);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // UART transmitter model: finishes each byte 1-4 cycles after its start unless stalled.
    initial begin
        forever begin
            tick();
            uart_tx_done = 1'b0;
            if (!reset_n) begin
                u_busy = 1'b0;
            end else if (uart_start_tx) begin
                u_busy = 1'b1;
                u_wait = int'($urandom_range(0, 3));
            end else if (u_busy && !uart_stall) begin
                if (u_wait == 0) begin
                    uart_tx_done = 1'b1;
                    u_busy = 1'b0;
                end else begin
                    u_wait--;
                end
            end
        end
    end

    // Monitor: classify every UART start by the frame window of the previous cycle.
    initial begin
        int occ;
        forever begin
            @(negedge clk);
            cyc++;
            if (!reset_n) begin
                check("rst_uart_start_tx", 32'(uart_start_tx), 32'(0));
                check("rst_uart_data", 32'(uart_data), 32'(0));
                check("rst_dbg_tx_done", 32'(dbg_tx_done), 32'(0));
                check("rst_dbg_timeout_err", 32'(dbg_timeout_err), 32'(0));
                check("rst_con_ready", 32'(con_ready), 32'(1));
                con_exp.delete();
                dbg_exp.delete();
                pushed = 0;
                con_sent = 0;
                inflight_dbg = 1'b0;
                lat_cyc = -1;
                err_due = -1;
                win_prev = 1'b0;
            end else begin
                if (uart_start_tx) begin
                    if (win_prev) begin
                        inflight_dbg = 1'b1;
                        if (dbg_exp.size() > 0) check("dbg_byte", 32'(uart_data), 32'(dbg_exp.pop_front()));
                        else check("dbg_spurious_start", 32'(uart_start_tx), 32'(0));
                    end else begin
                        inflight_dbg = 1'b0;
                        con_sent++;
                        if (con_exp.size() > 0) check("con_byte", 32'(uart_data), 32'(con_exp.pop_front()));
                        else check("con_spurious_start", 32'(uart_start_tx), 32'(0));
                    end
                end
                if (lat_cyc == cyc) begin
                    if (!win_prev) check("con_start_latency", 32'(uart_start_tx), 32'(1));
                    lat_cyc = -1;
                end
                check("dbg_tx_done", 32'(dbg_tx_done), 32'(uart_tx_done & inflight_dbg));
                check("dbg_timeout_err", 32'(dbg_timeout_err), 32'(err_due == 0));
                if (err_due == 0) win = 1'b0;
                if (err_due >= 0) err_due--;
                occ = pushed - con_sent;
                check("con_ready", 32'(con_ready), 32'(occ < int'(DEPTH)));
                if (con_valid && occ < int'(DEPTH)) begin
                    con_exp.push_back(con_data);
                    pushed++;
                end
                // A finished console byte with another one queued restarts the UART two cycles later.
                if (uart_tx_done && !inflight_dbg && !win && (pushed - con_sent) > 0) lat_cyc = cyc + 2;
                win_prev = win;
            end
        end
    end

    task automatic push_con(input logic [DW-1:0] b);
        con_valid = 1'b1;
        con_data = b;
        for (int i = 0; i < 500; i++) begin
            @(negedge clk);
            if (con_ready) break;
        end
        check("push_accept", 32'(con_ready), 32'(1));
        tick();
        con_valid = 1'b0;
    endtask

    task automatic con_burst(input int n);
        for (int i = 0; i < n; i++) begin
            push_con(8'($urandom));
            repeat ($urandom_range(0, 2)) tick();
        end
    endtask

    task automatic wait_dbg_done();
        for (int i = 0; i < 500; i++) begin
            @(negedge clk);
            if (dbg_tx_done) break;
        end
        check("dbg_tx_done_seen", 32'(dbg_tx_done), 32'(1));
        tick();
    endtask

    task automatic dbg_frame(input int n, input bit early, input bit fixed, input logic [DW-1:0] seed);
        logic [DW-1:0] b;
        dbg_frame_req = 1'b1;
        win = 1'b1;
        if (early) begin
            b = fixed ? seed : 8'($urandom);
            dbg_data = b;
            dbg_start_tx = 1'b1;
            dbg_exp.push_back(b);
        end
        tick();
        dbg_frame_req = 1'b0;
        dbg_start_tx = 1'b0;
        for (int i = 0; i < n; i++) begin
            if (i > 0 || !early) begin
                repeat ($urandom_range(0, 2)) tick();
                b = fixed ? ((i % 2 == 1) ? ~seed : seed) : 8'($urandom);
                dbg_data = b;
                dbg_start_tx = 1'b1;
                dbg_exp.push_back(b);
                tick();
                dbg_start_tx = 1'b0;
            end
            wait_dbg_done();
        end
        repeat ($urandom_range(0, 2)) tick();
        dbg_frame_done = 1'b1;
        win = 1'b0;
        tick();
        dbg_frame_done = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            if (con_exp.size() == 0 && dbg_exp.size() == 0 && !u_busy && !uart_start_tx) break;
        end
        check("drain_pending", 32'(con_exp.size() + dbg_exp.size()), 32'(0));
        tick();
        tick();
    endtask

    initial begin
        int n;
        reset_n = 1'b0;
        repeat (3) tick();
        reset_n = 1'b1;
        tick();

        // Console only
        push_con(8'h41);
        push_con(8'h42);
        push_con(8'h43);
        drain();

        // Frame atomicity: 0x41 in flight, three more queued, frame takes over
        uart_stall = 1'b1;
        for (int i = 0; i < 4; i++) push_con(8'h41 + 8'(i));
        repeat (2) tick();
        fork
            dbg_frame(3, 1'b0, 1'b1, 8'h5A);
            begin
                repeat (4) tick();
                uart_stall = 1'b0;
            end
        join
        drain();

        // Early start latched during CON_TX
        uart_stall = 1'b1;
        push_con(8'h41);
        repeat (3) tick();
        dbg_frame_req = 1'b1;
        dbg_start_tx = 1'b1;
        dbg_data = 8'h5A;
        dbg_exp.push_back(8'h5A);
        win = 1'b1;
        tick();
        dbg_frame_req = 1'b0;
        dbg_start_tx = 1'b0;
        tick();
        uart_stall = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (uart_tx_done) break;
        end
        check("con_done_seen", 32'(uart_tx_done), 32'(1));
        n = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            n++;
            if (uart_start_tx) break;
        end
        check("early_start_latency", 32'(n), 32'(3));
        wait_dbg_done();
        dbg_frame_done = 1'b1;
        win = 1'b0;
        tick();
        dbg_frame_done = 1'b0;
        drain();

        // Full FIFO with the UART stalled
        uart_stall = 1'b1;
        for (int i = 0; i < 5; i++) push_con(8'h60 + 8'(i));
        repeat (2) tick();
        check("fifo_full_ready", 32'(con_ready), 32'(0));
        con_valid = 1'b1;
        con_data = 8'hEE;
        repeat (4) tick();
        con_valid = 1'b0;
        check("fifo_full_reject", 32'(con_ready), 32'(0));
        uart_stall = 1'b0;
        drain();

        // Watchdog: frame with no start, console byte queued behind it
        dbg_frame_req = 1'b1;
        win = 1'b1;
        err_due = int'(TMO) + 1;
        tick();
        dbg_frame_req = 1'b0;
        push_con(8'h77);
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (dbg_timeout_err) break;
        end
        check("timeout_seen", 32'(dbg_timeout_err), 32'(1));
        tick();
        drain();

        // Randomized mix of console bursts and frames
        for (int it = 0; it < 25; it++) begin
            fork
                con_burst(int'($urandom_range(0, 6)));
                begin
                    repeat ($urandom_range(0, 8)) tick();
                    dbg_frame(int'($urandom_range(1, 4)), 1'($urandom), 1'b0, 8'h00);
                end
            join
            if ($urandom_range(0, 3) == 0) drain();
        end
        drain();

        // Reset during DBG_TX with console bytes queued
        uart_stall = 1'b1;
        dbg_frame_req = 1'b1;
        dbg_start_tx = 1'b1;
        dbg_data = 8'hC3;
        dbg_exp.push_back(8'hC3);
        win = 1'b1;
        tick();
        dbg_frame_req = 1'b0;
        dbg_start_tx = 1'b0;
        push_con(8'h11);
        push_con(8'h22);
        repeat (3) tick();
        check("pre_reset_dbg_byte", 32'(uart_data), 32'(8'hC3));
        reset_n = 1'b0;
        win = 1'b0;
        repeat (3) tick();
        uart_stall = 1'b0;
        reset_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            check("post_reset_quiet", 32'(uart_start_tx), 32'(0));
        end
        dbg_frame(2, 1'b0, 1'b0, 8'h00);
        con_burst(3);
        drain();

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
